// File: rtl/seg10_display_arb.sv
// Round-robin arbiter sharing one seg10 display between NREQ requesters.
// Each grant shows a latched digit for a fixed slot, then blanks and acks.
module seg10_display_arb #(
   parameter int NREQ        = 4,
   parameter int HOLD_CYCLES = 12000000,
   parameter int GAP_CYCLES  = 1200000,
   localparam int OW   = $clog2(NREQ),
   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES,
   localparam int TW   = $clog2(TMAX + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] value,
   output logic [NREQ-1:0]   ack,
   output logic [3:0]        digit,
   output logic              blank,
   output logic [OW-1:0]     owner,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHOW,
      S_GAP
   } state_t;

   state_t            r_state;
   logic [TW-1:0]     r_timer;
   logic [OW-1:0]     r_last;
   logic [OW-1:0]     r_owner;
   logic [3:0]        r_digit;
   logic              r_blank;
   logic              r_busy;
   logic [NREQ-1:0]   r_ack;

   logic              w_any;
   logic [OW-1:0]     w_pick;
   logic [3:0]        w_val;

   // Scan downward so the closest set bit after r_last wins.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(r_last) + k) % NREQ]) begin
            w_any  = 1'b1;
            w_pick = OW'((int'(r_last) + k) % NREQ);
         end
      end
      w_val = value[4*int'(w_pick) +: 4];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_last  <= OW'(NREQ - 1);
         r_owner <= '0;
         r_digit <= '0;
         r_blank <= 1'b1;
         r_busy  <= 1'b0;
         r_ack   <= '0;
      end else begin
         r_ack <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_SHOW;
                  r_digit <= w_val;
                  r_owner <= w_pick;
                  r_last  <= w_pick;
                  r_timer <= TW'(HOLD_CYCLES - 1);
                  r_blank <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_SHOW: begin
               if (r_timer == '0) begin
                  r_state <= S_GAP;
                  r_timer <= TW'(GAP_CYCLES - 1);
                  r_blank <= 1'b1;
                  r_ack   <= NREQ'(1) << r_owner;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            S_GAP: begin
               if (r_timer == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_blank <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ack   = r_ack;
   assign digit = r_digit;
   assign blank = r_blank;
   assign owner = r_owner;
   assign busy  = r_busy;

endmodule

// File: doc/seg10_display_arb.md
# seg10_display_arb

Round-robin display arbiter that shares the single 10-segment display driver between several requesters. Each requester presents a 4-bit digit value and a request. The arbiter grants one requester at a time and holds its latched value on the `digit` bus for a fixed display slot. It then inserts a blanking gap and acknowledges the requester. The block sits between the application logic and the seg10 decoder: `digit` feeds the decoder's `count` input, and `blank` gates the decoded segments off at the top level.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `HOLD_CYCLES`, 12000000: clock cycles a granted value is displayed (≥1).
- `GAP_CYCLES`, 1200000: clock cycles of blanking after each slot (≥1).
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester request level; held high until the matching `ack`.
- `value`  in  4*NREQ  requester i's digit on bits [4i+3:4i]; sampled only at grant.
- `ack`  out  NREQ  one-cycle pulse to the requester whose slot just ended.
- `digit`  out  4  value to the seg10 decoder.
- `blank`  out  1  high = segments must be off.
- `owner`  out  clog2(NREQ)  index of the current or most recent grantee.
- `busy`  out  1  high in SHOW and GAP.

## Operation
- Three-state FSM: IDLE, SHOW, GAP.
- **IDLE**
  - `blank`=1, `busy`=0.
  - If any `req` bit is high, choose the first set bit scanning upward from `last+1`, wrapping modulo NREQ.
  - Latch `value[owner]` into `digit`, load `owner`, set `last`=owner, load timer=HOLD_CYCLES-1, go to SHOW.
  - If no request, remain in IDLE.
- **SHOW**
  - `blank`=0, `digit` holds the latched value.
  - Changes on `value` or `req` are ignored; a requester that drops `req` mid-slot does not abort the slot.
  - Timer decrements each cycle. At timer==0: pulse `ack[owner]` next cycle, load timer=GAP_CYCLES-1, go to GAP.
- **GAP**
  - `blank`=1, `digit` holds its value. Timer decrements.
  - At timer==0 go to IDLE.
- **Re-requests:** a requester still asserting `req` when IDLE re-arbitrates is treated as a new request. Round-robin places it behind every other active requester.
- **Digit values:** all 16 values (0-15) pass through unchanged; no clamping at 9.
- **Timer width:** clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits, unsigned. It never underflows because each state exits at zero.
- **Reset (asynchronous, any state):**
  - FSM to IDLE, `digit`=0, `blank`=1, `ack`=0, `owner`=0, `busy`=0, timer=0.
  - `last`=NREQ-1, so requester 0 has first priority after reset.
  - A slot interrupted by reset is lost and produces no `ack`.

## Timing
- All outputs are registered.
- `req` high in an IDLE cycle at edge t gives SHOW from t+1: `blank` falls and `digit` is valid at t+1.
- SHOW lasts exactly HOLD_CYCLES cycles.
- The `ack` pulse coincides with the first GAP cycle and lasts exactly one cycle.
- GAP lasts exactly GAP_CYCLES cycles, followed by at least one IDLE cycle.
- Back-to-back slot period: 1 + HOLD_CYCLES + GAP_CYCLES cycles.
- Requesters must deassert `req` within one cycle after `ack`, or they re-queue.
- Simultaneous requests resolve in the same cycle by round-robin order; at most one grant per IDLE cycle.

## Test plan
Benches use HOLD_CYCLES=4, GAP_CYCLES=2, NREQ=4.
- **Reset values:** assert `reset` mid-SHOW → same cycle: `blank`=1, `busy`=0, `digit`=0, `ack`=0, no `ack` afterwards. After release, `req`=4'b1111 grants requester 0 first.
- **Single request:**
  - Stimulus: `req[2]`=1 with `value[11:8]`=7 at cycle 0, dropped on `ack`.
  - Required: `digit`=7, `blank`=0 for cycles 1-4.
  - `ack`=4'b0100 at cycle 5, `blank`=1 for cycles 5-6, IDLE at cycle 7.
- **Simultaneous requests:**
  - Stimulus: `req`=4'b0011 after reset, values 3 and 9.
  - Required: `digit` shows 3 for 4 cycles, gap, then 9. Second SHOW starts 7 cycles after the first, with acks 7 cycles apart.
- **Fairness:**
  - Stimulus: all four `req` held permanently.
  - Required: `owner` sequence 0,1,2,3,0,1…; each requester acked once per 28 cycles.
- **Latch and abort:**
  - Stimulus: change `value[3:0]` from 5 to 12 and drop `req[0]` during SHOW.
  - Required: `digit` stays 5 for the full slot and `ack[0]` still pulses.
- **Full digit range:** request with value 15 → `digit`=15 displayed unmodified for 4 cycles.
